// File: rtl/tdp_port_checker.sv
`default_nettype none
//==============================================================================
// Module   : tdp_port_checker
// Brief    : Per-port read-data scoreboard for a true-dual-port RAM. Keeps a
//            byte-valid shadow of the RAM, predicts READ_FIRST read data with
//            the RAM's output latency, and reports compare/error counts, the
//            first mismatch and an end-of-check handshake.
// Revision : 1.0 - initial release
//==============================================================================
module tdp_port_checker #(
  parameter int DATA_WIDTH   = 16,  // must equal 8 * BYTEEN_WIDTH
  parameter int ADDR_WIDTH   = 4,
  parameter int BYTEEN_WIDTH = 2,
  parameter int OUTPUT_REG   = 1,   // 0: unregistered RAM output, 1: registered
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clke,
  input  logic                    we,
  input  logic [BYTEEN_WIDTH-1:0] byteen,
  input  logic                    addren,
  input  logic                    bram_rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    sim_end,
  output logic [CNT_WIDTH-1:0]    chk_cnt,
  output logic [CNT_WIDTH-1:0]    err_cnt,
  output logic                    err_flag,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [DATA_WIDTH-1:0]   first_err_exp,
  output logic [DATA_WIDTH-1:0]   first_err_got,
  output logic                    done,
  output logic                    pass
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One in-flight read prediction; exp already has invalid lanes forced to 0.
  typedef struct packed {
    logic                    vld;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   exp;
    logic [BYTEEN_WIDTH-1:0] bmask;
  } pred_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;
  logic [DATA_WIDTH-1:0]   shadow_q [DEPTH];
  logic [DATA_WIDTH-1:0]   shadow_d [DEPTH];
  logic [BYTEEN_WIDTH-1:0] valid_q  [DEPTH];
  logic [BYTEEN_WIDTH-1:0] valid_d  [DEPTH];
  pred_t                   stg0_q, stg0_d;   // waiting for the RAM output register
  pred_t                   stg1_q, stg1_d;   // due for compare at the next edge
  logic [CNT_WIDTH-1:0]    chk_cnt_q, chk_cnt_d;
  logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
  logic                    err_flag_q, err_flag_d;
  logic [ADDR_WIDTH-1:0]   first_addr_q, first_addr_d;
  logic [DATA_WIDTH-1:0]   first_exp_q, first_exp_d;
  logic [DATA_WIDTH-1:0]   first_got_q, first_got_d;

  logic                    access;
  logic [ADDR_WIDTH-1:0]   eff_addr;
  pred_t                   new_pred;
  logic [DATA_WIDTH-1:0]   cmp_mask;
  logic                    cmp_fire;
  logic                    cmp_bad;
  logic                    pending;

  // Byte-lane valid bits expanded to a bit mask.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [BYTEEN_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < BYTEEN_WIDTH; i++) begin
      m[8*i +: 8] = {8{b[i]}};
    end
    return m;
  endfunction

  // Access decode, address hold and READ_FIRST prediction from the pre-write shadow.
  always_comb begin
    access         = clke && !bram_rst && (state_q != ST_DONE);
    eff_addr       = addren ? addr : addr_hold_q;
    addr_hold_d    = (access && addren) ? addr : addr_hold_q;
    new_pred.vld   = access;
    new_pred.addr  = eff_addr;
    new_pred.bmask = valid_q[eff_addr];
    new_pred.exp   = shadow_q[eff_addr] & lane_mask(valid_q[eff_addr]);
  end

  // Byte-lane write into the shadow and its valid bits.
  always_comb begin
    shadow_d = shadow_q;
    valid_d  = valid_q;
    if (access && we) begin
      for (int i = 0; i < BYTEEN_WIDTH; i++) begin
        if (byteen[i]) begin
          shadow_d[eff_addr][8*i +: 8] = wdata[8*i +: 8];
          valid_d[eff_addr][i]         = 1'b1;
        end
      end
    end
  end

  // Prediction pipeline: bram_rst flushes; with an output register the
  // prediction only advances on an enabled edge, otherwise it is due next edge.
  always_comb begin
    stg0_d = stg0_q;
    stg1_d = '0;
    if (bram_rst) begin
      stg0_d = '0;
      stg1_d = '0;
    end else if (OUTPUT_REG != 0) begin
      if (clke) begin
        stg1_d = stg0_q;
        stg0_d = new_pred;
      end
    end else begin
      stg0_d = '0;
      stg1_d = new_pred;
    end
  end

  // Compare of the due prediction against rdata; counters and first-error capture.
  always_comb begin
    cmp_mask     = lane_mask(stg1_q.bmask);
    cmp_fire     = stg1_q.vld && !bram_rst && (stg1_q.bmask != '0);
    cmp_bad      = cmp_fire && (((rdata ^ stg1_q.exp) & cmp_mask) != '0);
    chk_cnt_d    = chk_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_flag_d   = err_flag_q;
    first_addr_d = first_addr_q;
    first_exp_d  = first_exp_q;
    first_got_d  = first_got_q;
    if (cmp_fire) begin
      chk_cnt_d = chk_cnt_q + CNT_WIDTH'(1);
    end
    if (cmp_bad) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end
      err_flag_d = 1'b1;
      if (!err_flag_q) begin
        first_addr_d = stg1_q.addr;
        first_exp_d  = stg1_q.exp;
        first_got_d  = rdata & cmp_mask;
      end
    end
  end

  // End-of-check sequencing: wait for sim_end, drain outstanding predictions.
  always_comb begin
    pending = stg0_q.vld || stg1_q.vld;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sim_end) begin
          state_d = (pending || access) ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (!pending) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_hold_q  <= '0;
      stg0_q       <= '0;
      stg1_q       <= '0;
      chk_cnt_q    <= '0;
      err_cnt_q    <= '0;
      err_flag_q   <= 1'b0;
      first_addr_q <= '0;
      first_exp_q  <= '0;
      first_got_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_hold_q  <= addr_hold_d;
      stg0_q       <= stg0_d;
      stg1_q       <= stg1_d;
      chk_cnt_q    <= chk_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_flag_q   <= err_flag_d;
      first_addr_q <= first_addr_d;
      first_exp_q  <= first_exp_d;
      first_got_q  <= first_got_d;
    end
  end

  // Shadow valid bits; cleared by reset so stale data is never compared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
    end
  end

  // Shadow data; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign chk_cnt        = chk_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign err_flag       = err_flag_q;
  assign first_err_addr = first_addr_q;
  assign first_err_exp  = first_exp_q;
  assign first_err_got  = first_got_q;
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (err_cnt_q == '0);

endmodule
`default_nettype wire

// File: doc/tdp_port_checker.md
# tdp_port_checker

Scoreboard that sits directly downstream of the TDP RAM under test in the simulation bench. One instance per RAM port monitors the polarity-normalised stimulus driven into that port and the port's `rdata`. It keeps a shadow memory with per-byte valid bits, predicts read data with the configured output latency, and reports compare/error counts plus the first mismatch. The bench tops instantiate it on port A and port B, and gate end of simulation on `done`/`pass`.

## Interface
Parameters:
- `DATA_WIDTH`, 16: data width; must equal 8×`BYTEEN_WIDTH`.
- `ADDR_WIDTH`, 4: address width; the shadow depth is 2^`ADDR_WIDTH`.
- `BYTEEN_WIDTH`, 2: number of byte lanes.
- `OUTPUT_REG`, 1: 0 = unregistered RAM output, 1 = registered RAM output.
- `CNT_WIDTH`, 16: width of `chk_cnt` and `err_cnt`.

Ports:
- `clk` in 1: port clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `clke` in 1: clock enable, active-high after normalisation.
- `we` in 1: write enable.
- `byteen` in `BYTEEN_WIDTH`: byte-lane write enables.
- `addren` in 1: address enable; when 0, the previously latched address is held.
- `bram_rst` in 1: RAM output reset.
- `addr` in `ADDR_WIDTH`: address.
- `wdata` in `DATA_WIDTH`: write data.
- `rdata` in `DATA_WIDTH`: read data from the RAM port.
- `sim_end` in 1: stimulus generator finished.
- `chk_cnt` out `CNT_WIDTH`: number of compares performed.
- `err_cnt` out `CNT_WIDTH`: number of mismatching compares; saturates at all-ones.
- `err_flag` out 1: sticky; set on the first mismatch.
- `first_err_addr` out `ADDR_WIDTH`: address of the first mismatch.
- `first_err_exp` out `DATA_WIDTH`: expected data at the first mismatch; invalid bytes read 0.
- `first_err_got` out `DATA_WIDTH`: received `rdata` at the first mismatch, masked.
- `done` out 1: sticky end-of-check.
- `pass` out 1: `done` and `err_cnt`==0.

## Operation
**Access.** An access occurs at an edge where `clke`=1 and `bram_rst`=0.
- Effective address = `addren` ? `addr` : `addr_hold`.
- `addr_hold` loads `addr` on every access with `addren`=1. It resets to 0.

**Read.** Every access is a read. Write mode is READ_FIRST.
- The expected value is the shadow word *before* the write of the same edge.
- The valid mask is the shadow valid bits before that write.
- Both are pushed into a 2-entry prediction pipeline tagged with the effective address.

**Write.** Applied when `we`=1 on an access.
- For each lane i with `byteen`[i]=1: shadow[a][8i+7:8i] ← `wdata` lane i, and valid[a][i] ← 1.

**Shadow reset.** `rst` clears all valid bits. Shadow data is don't-care.

**Compare.** `mask` = the valid mask expanded to bits.
- The compare is skipped (no count change) when the mask is 0.
- Otherwise `chk_cnt`+1.
- If (`rdata`^exp)&`mask` ≠ 0: `err_cnt`+1 (saturating), and `err_flag` is set.
- On the first mismatch only, capture `first_err_addr`, `first_err_exp`&`mask`, and `rdata`&`mask`.

**`bram_rst`=1 at an edge.**
- No access, no shadow update, `addr_hold` unchanged.
- All pending predictions are discarded without compare.

**Done FSM.** States IDLE → DRAIN → DONE.
- IDLE → DRAIN when `sim_end`=1.
- DRAIN → DONE at the first edge with no pending prediction.
- DONE is sticky until `rst`.
- Accesses in DRAIN are still checked. Accesses in DONE are ignored.

## Timing
- Reset: every output is 0, the FSM is in IDLE, the pipeline is empty, and `addr_hold`=0.
- Access at edge N, `OUTPUT_REG`=0: `rdata` is compared at edge N+1, independent of `clke`.
- Access at edge N, `OUTPUT_REG`=1: the RAM output register loads at the next edge M>N with `clke`=1. `rdata` is compared at edge M+1.
  - Back-to-back accesses give one compare per edge.
  - The prediction waits while `clke`=0.
- The counters, `err_flag` and the capture registers update at the compare edge. They are visible in the following cycle.
- `done`: earliest is the edge after the last compare edge, or the same edge as `sim_end`=1 if nothing is pending. `pass` is combinational from `done` and `err_cnt`.
- An access and a compare on the same edge are independent. A write at edge N never affects the compare of an access made at N (READ_FIRST).
- `rst` asserted mid-operation clears everything immediately. The first access after `rst` falls behaves as from power-up.

## Test plan
- **Write then read, both parameter settings.** With `OUTPUT_REG`=1: write 0xA5C3 to addr 3 (`byteen`=2'b11), then read addr 3 with RAM returning 0xA5C3 at the compare edge → `chk_cnt`=1, `err_cnt`=0. Repeat with `OUTPUT_REG`=0, compare at N+1 → `chk_cnt`=1, `err_cnt`=0.
- **Partial write and masking.** Write 0x1234 to addr 5 with `byteen`=2'b01, then read returning 0xFF34 → no error (upper lane invalid), `chk_cnt`=1. Returning 0x0035 instead → `err_cnt`=1, `first_err_addr`=5, `first_err_exp`=0x0034, `first_err_got`=0x0035.
- **Address hold.** Write addr 7 with `addren`=1, then access with `addren`=0 and `addr`=2 → the compare uses addr 7. A corrupted `rdata` gives `first_err_addr`=7.
- **`clke` stall.** With `OUTPUT_REG`=1: access at edge 10, `clke`=0 at edges 11–13, `clke`=1 at edge 14 → exactly one compare, at edge 15.
- **`bram_rst` discard and reset mid-operation.**
  - `bram_rst`=1 one edge after a read → that read is not compared, `chk_cnt` unchanged.
  - `rst` pulsed while `err_cnt`=3 → all outputs 0 and valid bits cleared; a subsequent read of a previously written address → no compare.
- **End of simulation.** `sim_end`=1 with one compare pending → `done`=1 one edge after that compare, `pass`=1 if `err_cnt`=0. Force 0xFFFF+1 mismatches → `err_cnt` holds at 0xFFFF and `pass`=0.
